// File: rtl/amstrad_video_pkg.sv
// Shared video address mapping, word geometry and byte-lane selection.
package amstrad_video_pkg;

  // Bytes per VRAM word.
  function automatic int nbytes_of(int word_w);
    return word_w / 8;
  endfunction

  // Right shift from byte address to word address (16b words are the base unit).
  function automatic int addr_shift(int word_w);
    return $clog2(word_w / 16);
  endfunction

  // VRAM word-address width.
  function automatic int aw_of(int word_w, int bank_w);
    return 15 + bank_w - addr_shift(word_w);
  endfunction

  // Lane index width, at least one bit.
  function automatic int lane_w_of(int word_w);
    return (nbytes_of(word_w) > 2) ? $clog2(nbytes_of(word_w)) : 1;
  endfunction

  // CRTC to byte address: {vbank, ma[13:12], ra[2:0], ma[9:0]}; bank bits masked to bank_w.
  function automatic logic [22:0] byte_addr(logic [7:0] vbank, int bank_w,
                                            logic [13:0] ma, logic [4:0] ra);
    logic [22:0] a;
    logic [7:0]  mask;
    mask      = 8'((1 << bank_w) - 1);
    a         = {8'h00, ma[13:12], ra[2:0], ma[9:0]};
    a[22:15]  = vbank & mask;
    return a;
  endfunction

  // Pick logical byte lane idx out of a word; msb_first maps lane 0 to the top byte.
  function automatic logic [7:0] lane_pick(logic [63:0] word, int idx, int nbytes,
                                           bit msb_first);
    int phys;
    phys = msb_first ? (nbytes - 1 - idx) : idx;
    return word[8*phys +: 8];
  endfunction

endpackage

// File: rtl/amstrad_lane_mux.sv
// WORD_W-to-8 byte lane selector.
module amstrad_lane_mux
  import amstrad_video_pkg::*;
#(
  parameter int WORD_W         = 16,
  parameter int LANE_MSB_FIRST = 0
) (
  input  logic [WORD_W-1:0]            word,
  input  logic [lane_w_of(WORD_W)-1:0] sel,
  output logic [7:0]                   q
);

  assign q = lane_pick(64'(word), int'(sel), nbytes_of(WORD_W), LANE_MSB_FIRST != 0);

endmodule

// File: rtl/amstrad_vram_fetch.sv
// Gate-array video fetch: VRAM address generation and per-CAS byte delivery,
// with an optional one-lane byte shift carried across words.
module amstrad_vram_fetch
  import amstrad_video_pkg::*;
#(
  parameter int WORD_W         = 16,
  parameter int BANK_W         = 0,
  parameter int LANE_MSB_FIRST = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cpu_n,
  input  logic                                  ras_n,
  input  logic                                  cas_n,
  input  logic [13:0]                           crtc_ma,
  input  logic [4:0]                            crtc_ra,
  input  logic [((BANK_W > 0) ? BANK_W : 1)-1:0] vbank,
  input  logic                                  de,
  input  logic                                  shift_en,
  input  logic [WORD_W-1:0]                     vram_din,
  output logic [aw_of(WORD_W, BANK_W)-1:0]      vram_addr,
  output logic [7:0]                            vram_d,
  output logic [lane_w_of(WORD_W)-1:0]          lane,
  output logic                                  byte_stb
);

  localparam int NBYTES = nbytes_of(WORD_W);
  localparam int AW     = aw_of(WORD_W, BANK_W);
  localparam int LW     = lane_w_of(WORD_W);
  localparam int SH     = addr_shift(WORD_W);
  localparam logic [LW-1:0] LANE_MAX = LW'(NBYTES - 1);

  logic          cas_q;
  logic [7:0]    carry_q;
  logic          cas_rise;
  logic          capture;
  logic [7:0]    cur_byte;
  logic [7:0]    prev_byte;
  logic [LW-1:0] prev_lane;
  logic [7:0]    vbank8;
  logic [22:0]   baddr;

  assign vbank8    = 8'(vbank);
  assign baddr     = byte_addr(vbank8, BANK_W, crtc_ma, crtc_ra);
  assign cas_rise  = ~cas_q & cas_n;
  assign capture   = cpu_n & ~ras_n & ~cas_n;
  // lane-1 wraps at lane 0; that output is unused there (carry is taken instead).
  assign prev_lane = lane - LW'(1);

  amstrad_lane_mux #(.WORD_W(WORD_W), .LANE_MSB_FIRST(LANE_MSB_FIRST)) u_mux_cur (
    .word(vram_din), .sel(lane), .q(cur_byte)
  );

  amstrad_lane_mux #(.WORD_W(WORD_W), .LANE_MSB_FIRST(LANE_MSB_FIRST)) u_mux_prev (
    .word(vram_din), .sel(prev_lane), .q(prev_byte)
  );

  // CAS delay flop for rising-edge detection; idles high.
  always_ff @(posedge clk) begin
    if (reset) cas_q <= 1'b1;
    else       cas_q <= cas_n;
  end

  // Word address follows the CRTC during video slots, frozen during CPU slots.
  always_ff @(posedge clk) begin
    if (reset)      vram_addr <= '0;
    else if (cpu_n) vram_addr <= AW'(baddr >> SH);
  end

  // Lane counter: cleared in CPU slots, steps on each CAS rise, saturates at the top lane.
  always_ff @(posedge clk) begin
    if (reset)                                              lane <= '0;
    else if (!cpu_n)                                        lane <= '0;
    else if (cas_rise && !ras_n && lane != LANE_MAX)        lane <= lane + LW'(1);
  end

  // Byte capture; in shift mode the last lane is saved (blanked outside DE) for the next word.
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_d   <= 8'h00;
      byte_stb <= 1'b0;
      carry_q  <= 8'h00;
    end else begin
      byte_stb <= capture;
      if (capture) begin
        if (!shift_en)       vram_d <= cur_byte;
        else if (lane == '0) vram_d <= carry_q;
        else                 vram_d <= prev_byte;
        if (shift_en && lane == LANE_MAX) carry_q <= de ? cur_byte : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_amstrad_vram_fetch.sv
// Scoreboard bench: three configurations (16b; 32b; 64b with a bank bit, MSB-first lanes).
module tb_amstrad_vram_fetch;

  typedef struct {
    logic [7:0] d;
    int         ln;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, cpu_n, ras_n, cas_n, de, shift_en, vbank;
  logic [13:0] ma;
  logic [4:0]  ra;
  logic [63:0] din;

  logic [14:0] a16;
  logic [13:0] a32, a64;
  logic [0:0]  ln16;
  logic [1:0]  ln32;
  logic [2:0]  ln64;
  logic [7:0]  vd  [3];
  logic        stb [3];
  logic [2:0]  ln  [3];

  int errors = 0;
  int checks = 0;

  int   NB  [3] = '{2, 4, 8};
  bit   MSB [3] = '{1'b0, 1'b0, 1'b1};
  int   m_lane  [3];
  logic [7:0]  m_carry [3];
  logic [15:0] m_addr  [3];
  logic        m_casq;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  amstrad_vram_fetch #(.WORD_W(16)) dut16 (
    .clk(clk), .reset(reset), .cpu_n(cpu_n), .ras_n(ras_n), .cas_n(cas_n),
    .crtc_ma(ma), .crtc_ra(ra), .vbank(vbank), .de(de), .shift_en(shift_en),
    .vram_din(din[15:0]), .vram_addr(a16), .vram_d(vd[0]), .lane(ln16), .byte_stb(stb[0])
  );

  amstrad_vram_fetch #(.WORD_W(32)) dut32 (
    .clk(clk), .reset(reset), .cpu_n(cpu_n), .ras_n(ras_n), .cas_n(cas_n),
    .crtc_ma(ma), .crtc_ra(ra), .vbank(vbank), .de(de), .shift_en(shift_en),
    .vram_din(din[31:0]), .vram_addr(a32), .vram_d(vd[1]), .lane(ln32), .byte_stb(stb[1])
  );

  amstrad_vram_fetch #(.WORD_W(64), .BANK_W(1), .LANE_MSB_FIRST(1)) dut64 (
    .clk(clk), .reset(reset), .cpu_n(cpu_n), .ras_n(ras_n), .cas_n(cas_n),
    .crtc_ma(ma), .crtc_ra(ra), .vbank(vbank), .de(de), .shift_en(shift_en),
    .vram_din(din), .vram_addr(a64), .vram_d(vd[2]), .lane(ln64), .byte_stb(stb[2])
  );

  assign ln[0] = 3'(ln16);
  assign ln[1] = 3'(ln32);
  assign ln[2] = ln64;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Logical byte lane idx of din as seen by configuration i.
  function automatic logic [7:0] pick(input logic [63:0] w, input int idx, input int i);
    int p;
    p = MSB[i] ? (NB[i] - 1 - idx) : idx;
    return 8'(w >> (8 * p));
  endfunction

  function automatic logic [15:0] addr_of(input int i);
    logic [15:0] b;
    b = {(i == 2) ? vbank : 1'b0, ma[13:12], ra[2:0], ma[9:0]};
    return b >> i;  // shift 0/1/2 for 16/32/64-bit words
  endfunction

  task automatic sb_push(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int i, output exp_t e, output bit ok);
    ok = 1'b1;
    e  = '{8'h00, 0};
    case (i)
      0: if (q0.size() == 0) ok = 1'b0; else e = q0.pop_front();
      1: if (q1.size() == 0) ok = 1'b0; else e = q1.pop_front();
      default: if (q2.size() == 0) ok = 1'b0; else e = q2.pop_front();
    endcase
  endtask

  // Advance the expected state for the coming edge, then take the edge.
  task automatic step();
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_lane[i]  = 0;
        m_carry[i] = 8'h00;
        m_addr[i]  = 16'h0;
      end else begin
        if (cpu_n && !ras_n && !cas_n) begin
          logic [7:0] e;
          if (!shift_en)          e = pick(din, m_lane[i], i);
          else if (m_lane[i] == 0) e = m_carry[i];
          else                    e = pick(din, m_lane[i] - 1, i);
          if (shift_en && m_lane[i] == NB[i] - 1)
            m_carry[i] = de ? pick(din, NB[i] - 1, i) : 8'h00;
          sb_push(i, '{e, m_lane[i]});
        end
        if (!cpu_n) m_lane[i] = 0;
        else if (!m_casq && cas_n && !ras_n && m_lane[i] < NB[i] - 1) m_lane[i]++;
        if (cpu_n) m_addr[i] = addr_of(i);
      end
    end
    m_casq = reset ? 1'b1 : cas_n;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_addr(input string tag);
    chk({tag, "_a16"}, 64'(a16), 64'(m_addr[0]));
    chk({tag, "_a32"}, 64'(a32), 64'(m_addr[1]));
    chk({tag, "_a64"}, 64'(a64), 64'(m_addr[2]));
  endtask

  task automatic cpu_slot(input int n);
    cpu_n = 1'b0; ras_n = 1'b1; cas_n = 1'b1;
    repeat (n) step();
  endtask

  task automatic slot_open(input logic [63:0] w, input logic sh, input logic d);
    din = w; shift_en = sh; de = d;
    cpu_n = 1'b1; ras_n = 1'b0; cas_n = 1'b1;
    step();
  endtask

  task automatic cas_lo(); cas_n = 1'b0; step(); endtask
  task automatic cas_hi(); cas_n = 1'b1; step(); endtask

  // Every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (stb[i] === 1'b1) begin
        exp_t e;
        bit   ok;
        sb_pop(i, e, ok);
        if (!ok) chk($sformatf("stb_extra%0d", i), 64'd1, 64'd0);
        else begin
          chk($sformatf("sb_byte%0d", i), 64'(vd[i]), 64'(e.d));
          chk($sformatf("sb_lane%0d", i), 64'(ln[i]), 64'(e.ln));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; cpu_n = 1'b0; ras_n = 1'b1; cas_n = 1'b1;
    de = 1'b0; shift_en = 1'b0; vbank = 1'b0; ma = 14'h0; ra = 5'h0; din = 64'h0;
    m_casq = 1'b1;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_vd%0d", i),  64'(vd[i]),  64'h0);
      chk($sformatf("rst_ln%0d", i),  64'(ln[i]),  64'h0);
      chk($sformatf("rst_stb%0d", i), 64'(stb[i]), 64'h0);
    end
    chk_addr("rst");
    reset = 1'b0;

    // Direct mode, two CAS pulses.
    cpu_slot(2);
    ma = 14'h1234; ra = 5'h05;
    slot_open(64'h0123_4567_89AB_A55A, 1'b0, 1'b1);
    chk_addr("open1");
    cas_lo(); chk("d16_b0", 64'(vd[0]), 64'h5A); chk("d16_l0", 64'(ln[0]), 64'h0);
    cas_hi();
    cas_lo(); chk("d16_b1", 64'(vd[0]), 64'hA5); chk("d16_l1", 64'(ln[0]), 64'h1);
    cas_hi();

    // Shift mode with DE high: carry crosses into the next word.
    cpu_slot(2);
    slot_open(64'h0000_0000_0000_1122, 1'b1, 1'b1);
    cas_lo(); cas_hi(); cas_lo(); cas_hi();
    cpu_slot(2);
    slot_open(64'h0000_0000_0000_3344, 1'b1, 1'b1);
    cas_lo(); chk("sh_b0", 64'(vd[0]), 64'h11);
    cas_hi();
    cas_lo(); chk("sh_b1", 64'(vd[0]), 64'h44);
    cas_hi();

    // Shift mode with DE low in the first word: carry blanks.
    cpu_slot(2);
    slot_open(64'h0000_0000_0000_1122, 1'b1, 1'b0);
    cas_lo(); cas_hi(); cas_lo(); cas_hi();
    cpu_slot(2);
    slot_open(64'h0000_0000_0000_3344, 1'b1, 1'b1);
    cas_lo(); chk("shde_b0", 64'(vd[0]), 64'h00);
    cas_hi(); cas_lo(); cas_hi();

    // Saturation and top-of-range address.
    cpu_slot(2);
    ma = 14'h3FFF; ra = 5'h07; vbank = 1'b1;
    slot_open(64'hF1E2_D3C4_B5A6_9788, 1'b0, 1'b1);
    chk("max_a32", 64'(a32), 64'h3FFF);
    chk("max_a16", 64'(a16), 64'h7FFF);
    chk("max_a64", 64'(a64), 64'h3FFF);
    repeat (6) begin cas_lo(); cas_hi(); end
    chk("sat_l32", 64'(ln[1]), 64'h3);
    chk("sat_l16", 64'(ln[0]), 64'h1);

    // Full shift-mode words with random data on every width.
    for (int k = 0; k < 3; k++) begin
      cpu_slot(1);
      ma = 14'($urandom); ra = 5'($urandom); vbank = 1'($urandom);
      slot_open({$urandom, $urandom}, 1'b1, 1'(k != 1));
      chk_addr("rnd");
      repeat (8) begin cas_lo(); cas_hi(); end
    end

    // CPU slot cuts the burst: lane clears, data and address hold.
    cpu_slot(2);
    ma = 14'h0155; ra = 5'h02; vbank = 1'b0;
    slot_open(64'h0000_0000_0000_C37E, 1'b0, 1'b1);
    cas_lo(); cas_hi();
    cpu_n = 1'b0; ma = 14'h2AAA;
    step();
    cas_lo(); cas_hi();
    for (int i = 0; i < 3; i++) chk($sformatf("cut_ln%0d", i), 64'(ln[i]), 64'h0);
    chk("cut_vd16", 64'(vd[0]), 64'h7E);
    chk_addr("cut");

    // Reset mid-burst with a capture pending.
    slot_open(64'h0000_0000_0000_BEEF, 1'b0, 1'b1);
    cas_lo(); cas_hi();
    chk("pre_rst_l16", 64'(ln[0]), 64'h1);
    reset = 1'b1; cas_n = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mrst_vd%0d", i),  64'(vd[i]),  64'h0);
      chk($sformatf("mrst_ln%0d", i),  64'(ln[i]),  64'h0);
      chk($sformatf("mrst_stb%0d", i), 64'(stb[i]), 64'h0);
    end
    chk_addr("mrst");
    reset = 1'b0; cas_n = 1'b1;
    step();
    chk("post_rst_l16", 64'(ln[0]), 64'h0);
    cas_lo(); cas_hi();
    cpu_slot(2);

    chk("sb_empty", 64'(q0.size() + q1.size() + q2.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amstrad_vram_fetch.md
AMSTRAD_VRAM_FETCH -- requirements
Module: amstrad_vram_fetch

Interface
REQ-001 SHALL have parameter WORD_W, default 16, VRAM data word width in bits; legal values 16, 32, 64.
REQ-002 SHALL have parameter BANK_W, default 0, number of extra video-bank address bits prepended to the address.
REQ-003 SHALL have parameter LANE_MSB_FIRST, default 0: 0 = lane 0 is bits [7:0]; 1 = lane 0 is the top byte.
REQ-004 SHALL have derived constants NBYTES = WORD_W/8 and AW = 15 + BANK_W - log2(NBYTES/2).
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cpu_n  in  1  gate-array phase; 0 = CPU slot, 1 = video slot.
REQ-008 ras_n, cas_n  in  1 each  gate-array DRAM strobes, active low.
REQ-009 crtc_ma  in  14  CRTC memory address.
REQ-010 crtc_ra  in  5  CRTC raster address.
REQ-011 vbank  in  max(BANK_W,1)  video bank select; ignored when BANK_W=0.
REQ-012 de  in  1  CRTC display enable.
REQ-013 shift_en  in  1  sync-filter byte-shift mode request.
REQ-014 vram_din  in  WORD_W  VRAM read word.
REQ-015 vram_addr  out  AW  registered VRAM word address.
REQ-016 vram_d  out  8  byte presented to the gate array.
REQ-017 lane  out  log2(NBYTES) (min 1)  current byte lane index.
REQ-018 byte_stb  out  1  one-clk pulse when vram_d is updated.

Function
REQ-019 Byte address SHALL be {vbank, ma[13:12], ra[2:0], ma[9:0]}; vram_addr SHALL equal it right-shifted by log2(NBYTES/2).
REQ-020 While cpu_n=1, vram_addr SHALL load the byte address every clk; while cpu_n=0 it SHALL hold.
REQ-021 cas_n SHALL be registered once (cas_q); a CAS rising edge is cas_q=0 & cas_n=1.
REQ-022 While cpu_n=0, lane SHALL be cleared to 0 next clk.
REQ-023 While cpu_n=1, on a CAS rising edge with ras_n=0, lane SHALL increment, saturating at NBYTES-1 (no wrap).
REQ-024 Capture condition SHALL be cpu_n=1 & ras_n=0 & cas_n=0; vram_d updates one clk after the condition is sampled; byte_stb SHALL pulse in that same clk.
REQ-025 Direct mode (shift_en=0): vram_d SHALL take byte lane[lane] of vram_din, lane order per LANE_MSB_FIRST.
REQ-026 Shift mode (shift_en=1), lane>0: vram_d SHALL take byte lane[lane-1] of vram_din.
REQ-027 Shift mode, lane=0: vram_d SHALL take carry register carry_q.
REQ-028 Shift mode, lane=NBYTES-1 capture: carry_q SHALL load lane[NBYTES-1] if de=1, else 8'h00.
REQ-029 In direct mode carry_q SHALL hold.
REQ-030 A shift_en change SHALL take effect at the next capture; no flush.
REQ-031 If a CAS rising edge and capture coincide, the capture SHALL use the pre-increment lane.
REQ-032 If cpu_n falls mid-burst, lane SHALL clear and vram_d and carry_q SHALL hold.

Reset
REQ-033 On reset=1 at a clk edge, vram_addr, vram_d, carry_q and lane SHALL become 0, and byte_stb and cas_q SHALL become 0 and 1 respectively.
REQ-034 Reset SHALL override all other updates in the same clk.

Structure
REQ-035 A shared package amstrad_video_pkg SHALL hold the address-mapping function, NBYTES/AW derivation and the lane-select function.
REQ-036 One sub-module, amstrad_lane_mux (WORD_W-to-8 lane selector, LANE_MSB_FIRST aware), SHALL be instantiated twice: current lane and lane-1.

Verification
REQ-037 WORD_W=16, shift_en=0, din=16'hA55A, two CAS pulses in a video slot -> vram_d 8'h5A then 8'hA5; lane 0 then 1.
REQ-038 WORD_W=16, shift_en=1, de=1: slot 1 din=16'h1122, slot 2 din=16'h3344 -> slot 2 outputs 8'h11 then 8'h44.
REQ-039 Same as REQ-038 with de=0 in slot 1 -> slot 2 first byte 8'h00.
REQ-040 WORD_W=32, six CAS edges in one slot -> lane sequence 0,1,2,3,3,3 with no wrap; ma=14'h3FFF, ra=7 -> vram_addr=14'h3FFF.
REQ-041 reset asserted mid-burst with lane=1 -> next clk all outputs 0 and byte_stb=0.
REQ-042 cpu_n falls between the two CAS pulses -> lane=0, and vram_d and vram_addr hold until the next video slot.
